// File: rtl/jk_excite_drv_pkg.sv
// jk_pkg: shared definitions for the JK excitation driver.
//   - command op encodings (op_e)
//   - driver FSM state type (state_e)
//   - bin2gray / gray2bin helpers on a fixed GW-bit container. Narrower
//     buses are zero-extended in and truncated out. Zero upper bits do not
//     disturb either conversion.
package jk_pkg;

  localparam int GW = 64;  // widest bus the Gray helpers support

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_GRAY = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_CHECK
  } state_e;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR running from the MSB down.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/jk_excite_drv_if.sv
// jk_excite_drv_if: command/response bundle between a command source and
// the JK excitation driver.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/cmd_data     : op (jk_pkg::op_e) and absolute target for loads
//   rsp_valid/rsp_err   : one-cycle response and its mismatch flag
//   target_q            : latched target, held until the next accept
// The master modport is the command source. The slave modport is the driver.
interface jk_excite_drv_if #(
  parameter int WIDTH = 8
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_err;
  logic [WIDTH-1:0] target_q;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_err, target_q
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_err, target_q
  );
endinterface

// File: rtl/jk_excite_drv_cell.sv
// jk_excite_cell: one-bit inverse JK characteristic. Maps the present
// state p and the desired next state n to the excitation (j, k).
// Unchanged bits get j=k=0, which holds the cell. The don't-care half of a
// changing bit is resolved by the build option JK_EXCITE_TOGGLE_EN:
//   defined   : every changing bit toggles (j=k=1)
//   undefined : set-style for 0->1 (j=1,k=0), reset-style for 1->0 (j=0,k=1)
// Ports: p, n in; j, k out. Purely combinational.
module jk_excite_cell (
  input  logic p,
  input  logic n,
  output logic j,
  output logic k
);
`ifdef JK_EXCITE_TOGGLE_EN
  assign j = p ^ n;
  assign k = p ^ n;
`else
  assign j = ~p & n;
  assign k = p & ~n;
`endif
endmodule

// File: rtl/jk_excite_drv.sv
// jk_excite_drv: drives a bank of WIDTH external JK cells to a commanded
// next state, then reads the bank back and reports whether it got there.
//   clk, reset (async, active low)
//   bus      : jk_excite_drv_if.slave (command in, response/target out)
//   q_fb     : present state read back from the bank
//   j_out/k_out : excitation, non-zero only in the DRIVE cycle
//   drv_en   : high during the DRIVE cycle
// Sequence: IDLE (accept) -> DRIVE -> WAIT x SETTLE_CYC -> CHECK -> IDLE.
// Build option JK_EXCITE_TOGGLE_EN selects toggle-style excitation
// (see jk_excite_cell).
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1   // 1..15
) (
  input  logic             clk,
  input  logic             reset,
  jk_excite_drv_if.slave   bus,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             drv_en
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             drv_q, drv_d;
  logic             rdy_q, rdy_d;
  logic             rsp_q, rsp_d;

  logic [WIDTH-1:0] tgt;           // target computed from q_fb this cycle
  logic [WIDTH-1:0] exc_j, exc_k;  // excitation toward tgt

  // Target arithmetic, modulo 2^WIDTH. The Gray increment is truncated to
  // WIDTH before re-encoding so that the max code wraps to zero.
  always_comb begin
    tgt = bus.cmd_data;
    case (bus.cmd_op)
      OP_LOAD: tgt = bus.cmd_data;
      OP_INC:  tgt = q_fb + WIDTH'(1);
      OP_DEC:  tgt = q_fb - WIDTH'(1);
      OP_GRAY: tgt = WIDTH'(bin2gray(GW'(WIDTH'(gray2bin(GW'(q_fb)) + GW'(1)))));
      default: tgt = bus.cmd_data;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_excite_cell u_cell (
      .p (q_fb[i]),
      .n (tgt[i]),
      .j (exc_j[i]),
      .k (exc_k[i])
    );
  end

  // Every output except rsp_err is registered. The excitation is captured
  // straight into the j/k output flops on accept, so DRIVE presents it
  // with no extra stage.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    drv_d   = 1'b0;
    rdy_d   = 1'b0;
    rsp_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (bus.cmd_valid && rdy_q) begin
          state_d = ST_DRIVE;
          tgt_d   = tgt;
          j_d     = exc_j;
          k_d     = exc_k;
          drv_d   = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      ST_DRIVE: begin
        state_d = ST_WAIT;
        cnt_d   = 4'(SETTLE_CYC - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
          rsp_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drv_q   <= 1'b0;
      rdy_q   <= 1'b1;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drv_q   <= drv_d;
      rdy_q   <= rdy_d;
      rsp_q   <= rsp_d;
    end
  end

  assign j_out         = j_q;
  assign k_out         = k_q;
  assign drv_en        = drv_q;
  assign bus.cmd_ready = rdy_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.target_q  = tgt_q;
  // The bank is compared live during CHECK. q_fb only has to be stable then.
  assign bus.rsp_err   = rsp_q && (q_fb != tgt_q);

endmodule
